// File: rtl/summ_complex_arbiter_pkg.sv
// Shared definitions for the complex-adder arbiter: default data width,
// a constant-foldable clog2 helper and the arbitration FSM state type.
package summ_complex_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

endpackage

// File: rtl/summ_complex_arbiter_adder.sv
// Registered complex adder: one cycle latency, enable-gated, no reset.
// Wrap-around arithmetic, no saturation or carry out.
module summComplex
    import summ_complex_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_re_i,
    input  logic [DATA_W-1:0] a_im_i,
    input  logic [DATA_W-1:0] b_re_i,
    input  logic [DATA_W-1:0] b_im_i,
    output logic [DATA_W-1:0] sum_re_o,
    output logic [DATA_W-1:0] sum_im_o
);

    logic [DATA_W-1:0] sum_re_q;
    logic [DATA_W-1:0] sum_im_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            sum_re_q <= a_re_i + b_re_i;
            sum_im_q <= a_im_i + b_im_i;
        end
    end

    assign sum_re_o = sum_re_q;
    assign sum_im_o = sum_im_q;

endmodule

// File: rtl/summ_complex_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered complex adder
// among NUM_REQ requesters; results carry owner ID and last flag.
module summ_complex_arbiter
    import summ_complex_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_q,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_q,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [ID_W-1:0]           out_id,
    output logic [DATA_W-1:0]         out_i,
    output logic [DATA_W-1:0]         out_q,
    output logic                      busy
);

    state_e            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   owner_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [ID_W-1:0]   out_id_q;
    logic              have_sum_q;

    logic [ID_W-1:0]   grant_d;
    logic [ID_W-1:0]   ptr_next_d;
    logic              own_valid;
    logic              own_last;
    logic              beat;
    logic [DATA_W-1:0] sel_a_re;
    logic [DATA_W-1:0] sel_a_im;
    logic [DATA_W-1:0] sel_b_re;
    logic [DATA_W-1:0] sel_b_im;
    logic [DATA_W-1:0] sum_re;
    logic [DATA_W-1:0] sum_im;

    // First requesting index at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant_d    = rr_pick(req_valid, rr_ptr_q);
    assign ptr_next_d = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        sel_a_re  = '0;
        sel_a_im  = '0;
        sel_b_re  = '0;
        sel_b_im  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (owner_q == ID_W'(k)) begin
                own_valid = req_valid[k];
                own_last  = req_last[k];
                sel_a_re  = req_a_i[k*DATA_W +: DATA_W];
                sel_a_im  = req_a_q[k*DATA_W +: DATA_W];
                sel_b_re  = req_b_i[k*DATA_W +: DATA_W];
                sel_b_im  = req_b_q[k*DATA_W +: DATA_W];
            end
        end
    end

    assign beat = (state_q == ST_BURST) && own_valid;

    always_comb begin
        req_ready = '0;
        if (state_q == ST_BURST) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                req_ready[k] = (owner_q == ID_W'(k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
            have_sum_q  <= 1'b0;
        end else begin
            out_valid_q <= beat;
            if (beat) begin
                out_last_q <= own_last;
                out_id_q   <= owner_q;
                have_sum_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        owner_q <= grant_d;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (beat && own_last) begin
                        rr_ptr_q <= ptr_next_d;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    summComplex #(
        .DATA_W (DATA_W)
    ) u_adder (
        .clk      (clk),
        .en_i     (beat),
        .a_re_i   (sel_a_re),
        .a_im_i   (sel_a_im),
        .b_re_i   (sel_b_re),
        .b_im_i   (sel_b_im),
        .sum_re_o (sum_re),
        .sum_im_o (sum_im)
    );

    // The adder has no reset; mask its output until a real result exists.
    assign out_i     = have_sum_q ? sum_re : '0;
    assign out_q     = have_sum_q ? sum_im : '0;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_summ_complex_arbiter.sv
// Directed bench for summ_complex_arbiter with a cycle-level reference model
// and hand-computed literal expectations.
module tb_summ_complex_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_a_i, req_a_q, req_b_i, req_b_q;
    logic [N-1:0]    req_ready;
    logic            out_valid, out_last, busy;
    logic [IW-1:0]   out_id;
    logic [DW-1:0]   out_i, out_q;

    always #5 clk = ~clk;

    summ_complex_arbiter #(
        .NUM_REQ (N),
        .ID_W    (IW),
        .DATA_W  (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_a_i   (req_a_i),
        .req_a_q   (req_a_q),
        .req_b_i   (req_b_i),
        .req_b_q   (req_b_q),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_i     (out_i),
        .out_q     (out_q),
        .busy      (busy)
    );

    typedef struct {
        bit        v;
        bit        last;
        bit [15:0] ai, aq, bi, bq;
    } beat_t;

    beat_t src [N][$];
    int    id_log[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: who holds the adder, who is favoured next, last result.
    bit        m_burst;
    int        m_owner;
    int        m_prio;
    bit        m_ov, m_ol;
    int        m_id;
    bit [15:0] m_i, m_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_burst = 1'b0;
        m_owner = 0;
        m_prio  = 0;
        m_ov    = 1'b0;
        m_ol    = 1'b0;
        m_id    = 0;
        m_i     = '0;
        m_q     = '0;
    endtask

    task automatic m_step();
        int k;
        m_ov = 1'b0;
        if (!m_burst) begin
            for (int off = N - 1; off >= 0; off--) begin
                k = (m_prio + off) % N;
                if (req_valid[k]) begin
                    m_owner = k;
                    m_burst = 1'b1;
                end
            end
        end else if (req_valid[m_owner]) begin
            m_ov = 1'b1;
            m_id = m_owner;
            m_ol = req_last[m_owner];
            m_i  = 16'(req_a_i[m_owner*DW +: DW] + req_b_i[m_owner*DW +: DW]);
            m_q  = 16'(req_a_q[m_owner*DW +: DW] + req_b_q[m_owner*DW +: DW]);
            if (m_ol) begin
                m_burst = 1'b0;
                m_prio  = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] er;
        er = '0;
        if (m_burst) er[m_owner] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'(m_burst));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_id", 32'(out_id), 32'(m_id));
            chk("out_last", 32'(out_last), 32'(m_ol));
        end
        chk("out_i", 32'(out_i), 32'(m_i));
        chk("out_q", 32'(out_q), 32'(m_q));
        if (out_valid === 1'b1) id_log.push_back(int'(out_id));
    endtask

    task automatic drive();
        beat_t b;
        for (int k = 0; k < N; k++) begin
            if (src[k].size() > 0) begin
                b = src[k][0];
                req_valid[k] = b.v;
                req_last[k]  = b.last;
                req_a_i[k*DW +: DW] = b.ai;
                req_a_q[k*DW +: DW] = b.aq;
                req_b_i[k*DW +: DW] = b.bi;
                req_b_q[k*DW +: DW] = b.bq;
            end else begin
                req_valid[k] = 1'b0;
                req_last[k]  = 1'b0;
                req_a_i[k*DW +: DW] = '0;
                req_a_q[k*DW +: DW] = '0;
                req_b_i[k*DW +: DW] = '0;
                req_b_q[k*DW +: DW] = '0;
            end
        end
    endtask

    // One clock: model and compare 2ns after the edge, advance sources, re-drive at negedge.
    task automatic tick();
        logic [N-1:0] snap;
        snap = req_ready;
        @(posedge clk);
        #2;
        if (!rst_n) m_reset();
        else        m_step();
        compare();
        for (int k = 0; k < N; k++) begin
            if (src[k].size() > 0) begin
                if (!src[k][0].v || snap[k]) src[k].delete(0);
            end
        end
        @(negedge clk);
        drive();
    endtask

    task automatic add_pkt(input int k, input int nbeats,
                           input bit [15:0] ai, input bit [15:0] aq,
                           input bit [15:0] bi, input bit [15:0] bq);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.v = 1'b1; b.last = (i == nbeats - 1);
            b.ai = ai; b.aq = aq; b.bi = bi; b.bq = bq;
            src[k].push_back(b);
        end
    endtask

    task automatic add_gap(input int k, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.v = 1'b0; b.last = 1'b1;
            b.ai = '0; b.aq = '0; b.bi = '0; b.bq = '0;
            src[k].push_back(b);
        end
    endtask

    function automatic bit all_idle();
        bit r;
        r = !m_burst;
        for (int k = 0; k < N; k++) if (src[k].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (!all_idle() && n < maxc) begin
            tick();
            n++;
        end
        if (!all_idle()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: still active after %0d cycles", maxc);
        end
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        for (int k = 0; k < N; k++) src[k].delete();
        drive();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_log(input string name, input int exp[]);
        chk({name, "_len"}, 32'(id_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < id_log.size(); i++)
            chk(name, 32'(id_log[i]), 32'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        drive();
        @(negedge clk);
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_last", 32'(out_last), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        chk("rst_out_i", 32'(out_i), 32'h0);
        chk("rst_out_q", 32'(out_q), 32'h0);
        rst_n = 1'b1;

        // Single requester 2, three beats (1,2)+(3,4).
        add_pkt(2, 3, 16'd1, 16'd2, 16'd3, 16'd4);
        drive();
        tick();
        chk("t1_ready", 32'(req_ready), 32'h4);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_nov", 32'(out_valid), 32'h0);
        tick();
        chk("t1_ov1", 32'(out_valid), 32'h1);
        chk("t1_i", 32'(out_i), 32'h4);
        chk("t1_q", 32'(out_q), 32'h6);
        chk("t1_id", 32'(out_id), 32'h2);
        chk("t1_last1", 32'(out_last), 32'h0);
        tick();
        chk("t1_ov2", 32'(out_valid), 32'h1);
        chk("t1_last2", 32'(out_last), 32'h0);
        tick();
        chk("t1_ov3", 32'(out_valid), 32'h1);
        chk("t1_last3", 32'(out_last), 32'h1);
        tick();
        chk("t1_done", 32'(out_valid), 32'h0);
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_hold", 32'(out_i), 32'h4);
        drain(20);

        // Contention: all four with 2-beat packets, requester 0 twice.
        do_reset();
        id_log.delete();
        add_pkt(0, 2, 16'h0010, 16'h0020, 16'h0001, 16'h0002);
        add_pkt(0, 2, 16'h0050, 16'h0060, 16'h0005, 16'h0006);
        add_pkt(1, 2, 16'h0110, 16'h0120, 16'h0011, 16'h0012);
        add_pkt(2, 2, 16'h0210, 16'h0220, 16'h0021, 16'h0022);
        add_pkt(3, 2, 16'h0310, 16'h0320, 16'h0031, 16'h0032);
        drive();
        drain(100);
        chk_log("cont_order", '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0});

        // Fairness: 3 finishes, then 0 and 3 compete.
        add_pkt(3, 1, 16'h1000, 16'h2000, 16'h0003, 16'h0004);
        drive();
        drain(20);
        id_log.delete();
        add_pkt(0, 1, 16'h0A00, 16'h0B00, 16'h000A, 16'h000B);
        add_pkt(3, 1, 16'h0C00, 16'h0D00, 16'h000C, 16'h000D);
        drive();
        drain(20);
        chk_log("fair_order", '{0, 3});

        // Wrap arithmetic.
        add_pkt(1, 1, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF);
        drive();
        drain(20);
        chk("wrap_i", 32'(out_i), 32'h8000);
        chk("wrap_q", 32'(out_q), 32'h7FFF);

        // Gap: owner 2 drops valid for 2 cycles while requester 1 waits.
        add_pkt(2, 1, 16'd10, 16'd20, 16'd30, 16'd40);
        src[2][0].last = 1'b0;
        add_gap(2, 2);
        add_pkt(2, 1, 16'd5, 16'd6, 16'd7, 16'd8);
        drive();
        tick();
        add_pkt(1, 1, 16'd100, 16'd200, 16'd1, 16'd2);
        drive();
        tick();
        chk("gap_beat1", 32'(out_valid), 32'h1);
        for (int g = 0; g < 2; g++) begin
            tick();
            chk("gap_busy", 32'(busy), 32'h1);
            chk("gap_ready", 32'(req_ready), 32'h4);
            chk("gap_nov", 32'(out_valid), 32'h0);
        end
        drain(20);

        // Reset mid-burst during beat 2 of requester 3.
        add_pkt(3, 3, 16'd1, 16'd1, 16'd1, 16'd1);
        drive();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmb_valid", 32'(out_valid), 32'h0);
        chk("rmb_ready", 32'(req_ready), 32'h0);
        chk("rmb_busy", 32'(busy), 32'h0);
        chk("rmb_out_i", 32'(out_i), 32'h0);
        m_reset();
        for (int k = 0; k < N; k++) src[k].delete();
        drive();
        tick();
        rst_n = 1'b1;
        id_log.delete();
        add_pkt(1, 1, 16'd3, 16'd3, 16'd3, 16'd3);
        add_pkt(0, 1, 16'd2, 16'd2, 16'd2, 16'd2);
        drive();
        drain(20);
        chk_log("rmb_order", '{0, 1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
